// File: rtl/multi_clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel CLOCK_50 divider.
// Optional sync clear is enabled by MULTI_CLOCK_DIVIDER_SYNC_CLR_EN (see top).
package multi_clock_divider_pkg;

    localparam int CLK_HZ             = 50_000_000;
    localparam int DEFAULT_HALF_100HZ = 250_000;

    // Channel-select width; a single channel still gets a 1-bit select port.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int half_for_hz(input int hz);
        return CLK_HZ / (2 * hz);
    endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: half-period register, divider counter, square output,
// rise tick and tick event counter, all in the CLOCK_50 domain.
module clock_div_channel
    import multi_clock_divider_pkg::*;
#(
    parameter int DIV_W        = 26,
    parameter int CNT_W        = 10,
    parameter int DEFAULT_HALF = DEFAULT_HALF_100HZ
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             en,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_half,
    input  logic             clr,
    output logic             sq_out,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] eff_half;
    logic             terminal;

    // A zero half-period behaves as one so the output toggles every cycle.
    assign eff_half = (half == '0) ? DIV_W'(1) : half;
    assign terminal = (div_cnt == eff_half - DIV_W'(1));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            half    <= DIV_W'(DEFAULT_HALF);
            div_cnt <= '0;
            sq_out  <= 1'b0;
            tick    <= 1'b0;
            count   <= '0;
        end else begin
            // The counter trails tick by one cycle so every tick is accounted.
            count <= count + CNT_W'(tick);
            tick  <= 1'b0;
            if (clr) begin
                div_cnt <= '0;
                sq_out  <= 1'b0;
            end else if (wr) begin
                half    <= wr_half;
                div_cnt <= '0;
            end else if (en) begin
                if (terminal) begin
                    div_cnt <= '0;
                    sq_out  <= ~sq_out;
                    tick    <= ~sq_out;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent square-wave dividers off CLOCK_50 with runtime half-periods.
// Define MULTI_CLOCK_DIVIDER_SYNC_CLR_EN to add the sync_clr phase-align input.
module multi_clock_divider
    import multi_clock_divider_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int DIV_W        = 26,
    parameter int CNT_W        = 10,
    parameter int DEFAULT_HALF = DEFAULT_HALF_100HZ
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET_N,
`ifdef MULTI_CLOCK_DIVIDER_SYNC_CLR_EN
    input  logic                      sync_clr,
`endif
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic                      wr_en,
    input  logic [ch_w(NUM_CH)-1:0]   wr_ch,
    input  logic [DIV_W-1:0]          wr_half,
    output logic [NUM_CH-1:0]         sq_out,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH*CNT_W-1:0]   count
);

    localparam int CH_W = ch_w(NUM_CH);

    logic clr_all;

`ifdef MULTI_CLOCK_DIVIDER_SYNC_CLR_EN
    assign clr_all = sync_clr;
`else
    assign clr_all = 1'b0;
`endif

    // Selects at or above NUM_CH match no channel, so such writes fall away.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_sel;

        assign wr_sel = wr_en && (wr_ch == CH_W'(i));

        clock_div_channel #(
            .DIV_W        (DIV_W),
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .CLOCK_50 (CLOCK_50),
            .RESET_N  (RESET_N),
            .en       (ch_en[i]),
            .wr       (wr_sel),
            .wr_half  (wr_half),
            .clr      (clr_all),
            .sq_out   (sq_out[i]),
            .tick     (tick[i]),
            .count    (count[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider (3 channels, short default half-period).
module tb_multi_clock_divider;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 26;
    localparam int CNT_W  = 10;
    localparam int DHALF  = 20;

    logic              CLOCK_50;
    logic              RESET_N;
    logic              sync_clr;
    logic [NUM_CH-1:0] ch_en;
    logic              wr_en;
    logic [1:0]        wr_ch;
    logic [DIV_W-1:0]  wr_half;
    logic [NUM_CH-1:0] sq_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH*CNT_W-1:0] count;

    int checks = 0;
    int errors = 0;

    multi_clock_divider #(
        .NUM_CH       (NUM_CH),
        .DIV_W        (DIV_W),
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DHALF)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
`ifdef MULTI_CLOCK_DIVIDER_SYNC_CLR_EN
        .sync_clr (sync_clr),
`endif
        .ch_en    (ch_en),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_half  (wr_half),
        .sq_out   (sq_out),
        .tick     (tick),
        .count    (count)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(input int ch);
        return count[ch*CNT_W +: CNT_W];
    endfunction

    initial begin
        RESET_N  = 1'b0;
        sync_clr = 1'b0;
        ch_en    = '0;
        wr_en    = 1'b0;
        wr_ch    = '0;
        wr_half  = '0;
        step(3);
        check_val("rst_sq", sq_out, 0);
        check_val("rst_tick", tick, 0);
        check_val("rst_count", count, 0);

        // default half-period: all channels rise together after DHALF edges
        RESET_N = 1'b1;
        ch_en   = 3'b111;
        step(DHALF - 1);
        check_val("dflt_pre_sq", sq_out, 3'b000);
        step(1);
        check_val("dflt_rise_sq", sq_out, 3'b111);
        check_val("dflt_rise_tick", tick, 3'b111);
        step(1);
        check_val("dflt_tick_off", tick, 3'b000);
        check_val("dflt_count", count, {10'd1, 10'd1, 10'd1});

        // asynchronous reset in the middle of a running period
        RESET_N = 1'b0;
        #2;
        check_val("async_sq", sq_out, 0);
        check_val("async_tick", tick, 0);
        check_val("async_count", count, 0);
        ch_en = '0;
        #4;
        RESET_N = 1'b1;

        // ch0 half=3: period 6, rises at edges 3,9,15,...
        wr_en = 1'b1; wr_ch = 2'd0; wr_half = 26'd3; ch_en = 3'b001;
        step(1);
        wr_en = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            step(1);
            check_val($sformatf("h3_tick_c%0d", c), tick[0], ((c % 6) == 3));
            check_val($sformatf("h3_sq_c%0d", c), sq_out[0], ((c % 6) >= 3));
        end
        check_val("h3_count", cnt_of(0), 5);
        check_val("h3_ch1_idle", cnt_of(1), 0);

        // ch1 half=0: toggle every cycle, count wraps after 1024 ticks
        wr_en = 1'b1; wr_ch = 2'd1; wr_half = 26'd0; ch_en = 3'b010;
        step(1);
        wr_en = 1'b0;
        step(1);
        check_val("h0_e1_sq", sq_out[1], 1);
        check_val("h0_e1_tick", tick[1], 1);
        step(1);
        check_val("h0_e2_sq", sq_out[1], 0);
        check_val("h0_e2_tick", tick[1], 0);
        check_val("h0_e2_count", cnt_of(1), 1);
        step(2044);
        check_val("h0_count_1023", cnt_of(1), 1023);
        step(2);
        check_val("h0_count_wrap", cnt_of(1), 0);
        check_val("h0_ch0_held_cnt", cnt_of(0), 5);
        check_val("h0_ch0_held_sq", sq_out[0], 0);

        // ch0 half=4, freeze for 7 cycles while high, then resume
        wr_en = 1'b1; wr_ch = 2'd0; wr_half = 26'd4; ch_en = 3'b001;
        step(1);
        wr_en = 1'b0;
        step(3);
        check_val("h4_pre_sq", sq_out[0], 0);
        step(1);
        check_val("h4_rise_sq", sq_out[0], 1);
        check_val("h4_rise_tick", tick[0], 1);
        step(2);
        check_val("h4_count6", cnt_of(0), 6);
        ch_en = 3'b000;
        for (int k = 0; k < 7; k++) begin
            step(1);
            check_val($sformatf("frz_sq_%0d", k), sq_out[0], 1);
            check_val($sformatf("frz_tick_%0d", k), tick[0], 0);
            check_val($sformatf("frz_cnt_%0d", k), cnt_of(0), 6);
        end
        ch_en = 3'b001;
        step(1);
        check_val("res_r1_sq", sq_out[0], 1);
        step(1);
        check_val("res_r2_sq", sq_out[0], 0);
        step(3);
        check_val("res_r5_sq", sq_out[0], 0);
        step(1);
        check_val("res_r6_sq", sq_out[0], 1);
        check_val("res_r6_tick", tick[0], 1);
        step(1);
        check_val("res_r7_count", cnt_of(0), 7);

        // write half=2 in the cycle the counter sits at terminal: write wins
        step(2);
        wr_en = 1'b1; wr_ch = 2'd0; wr_half = 26'd2;
        step(1);
        wr_en = 1'b0;
        check_val("wt_sq_hold", sq_out[0], 1);
        check_val("wt_no_tick", tick[0], 0);
        step(1);
        check_val("wt_r11_sq", sq_out[0], 1);
        step(1);
        check_val("wt_r12_sq", sq_out[0], 0);
        step(2);
        check_val("wt_r14_sq", sq_out[0], 1);
        check_val("wt_r14_tick", tick[0], 1);
        check_val("wt_r14_count", cnt_of(0), 7);

        // out-of-range channel select must not touch any channel
        wr_en = 1'b1; wr_ch = 2'd3; wr_half = 26'd5;
        step(1);
        wr_en = 1'b0;
        check_val("bad_ch_count", cnt_of(0), 8);
        step(1);
        check_val("bad_ch_sq", sq_out[0], 0);
        check_val("bad_ch_others_sq", sq_out[2:1], 2'b00);
        check_val("bad_ch_ch2_cnt", cnt_of(2), 0);

`ifdef MULTI_CLOCK_DIVIDER_SYNC_CLR_EN
        // phase-align ch0 (half 3) and ch1 (half 5) with sync_clr
        ch_en = 3'b011;
        wr_en = 1'b1; wr_ch = 2'd0; wr_half = 26'd3;
        step(1);
        wr_ch = 2'd1; wr_half = 26'd5;
        step(1);
        wr_en = 1'b0;
        step(4);
        sync_clr = 1'b1;
        step(1);
        sync_clr = 1'b0;
        check_val("sclr_sq", sq_out[1:0], 2'b00);
        check_val("sclr_tick", tick[1:0], 2'b00);
        step(2);
        check_val("sclr_s2_sq", sq_out[1:0], 2'b00);
        step(1);
        check_val("sclr_s3_sq", sq_out[1:0], 2'b01);
        check_val("sclr_s3_tick", tick[1:0], 2'b01);
        step(2);
        check_val("sclr_s5_sq", sq_out[1:0], 2'b11);
        check_val("sclr_s5_tick", tick[1:0], 2'b10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
